// File: rtl/dispatch_sequencer.sv
// Sequencer for the double-buffered dispatcher: fills the write buffer row by row and drains the
// read buffer bit-serially, ping-ponging between them. Optional stall counter: DISPATCH_SEQ_PERF_EN.
module dispatch_sequencer #(
  parameter int WL               = 16,
  parameter int BRICKS_PER_ROW   = 16,
  parameter int PARALLEL_WINDOWS = 16,
  parameter int SEL_BITS         = 4,
  parameter int TW               = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_start,
  input  logic [TW-1:0]                          i_num_tiles,
  input  logic [SEL_BITS*PARALLEL_WINDOWS-1:0]   i_brick_sel,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_mem_req,
  input  logic                                   i_mem_valid,
  output logic [SEL_BITS*PARALLEL_WINDOWS-1:0]   o_sel,
  output logic [PARALLEL_WINDOWS-1:0]            o_enable,
  output logic                                   o_read_buf,
  output logic                                   o_stream_valid,
  output logic [$clog2(WL)-1:0]                  o_bit_idx,
  input  logic                                   i_stream_ready
`ifdef DISPATCH_SEQ_PERF_EN
  ,
  output logic [31:0]                            o_stall_cnt
`endif
);

  localparam int PW    = PARALLEL_WINDOWS;
  localparam int BIT_W = $clog2(WL);
  localparam int ROW_W = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WL - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PW - 1);

  // The brick select must be able to address every brick of a row.
  if (SEL_BITS < $clog2(BRICKS_PER_ROW)) begin : g_sel_width_check
    $error("dispatch_sequencer: SEL_BITS too narrow for BRICKS_PER_ROW");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state_r;
  logic [TW-1:0]               num_tiles_r;
  logic [SEL_BITS*PW-1:0]      sel_r;
  logic                        read_buf_r;
  logic [1:0]                  buf_full_r;
  logic [ROW_W-1:0]            row_k_r;
  logic [TW-1:0]               tiles_filled_r;
  logic [TW-1:0]               tiles_drained_r;
  logic [BIT_W-1:0]            bit_idx_r;

  logic                        rd_full_s;
  logic                        wr_full_s;
  logic                        mem_req_s;
  logic                        fill_s;
  logic                        stream_valid_s;
  logic                        accept_s;
  logic                        swap_s;
  logic [PW-1:0]               enable_s;

  // Handshake decode; a swap cycle naturally has neither request nor valid.
  always_comb begin
    rd_full_s      = buf_full_r[read_buf_r];
    wr_full_s      = buf_full_r[~read_buf_r];
    mem_req_s      = (state_r == S_RUN) && !wr_full_s && (tiles_filled_r < num_tiles_r);
    fill_s         = mem_req_s && i_mem_valid;
    stream_valid_s = (state_r == S_RUN) && rd_full_s;
    accept_s       = stream_valid_s && i_stream_ready;
    swap_s         = (state_r == S_RUN) && !rd_full_s && wr_full_s;
    if (fill_s) begin
      enable_s = PW'(1) << row_k_r;
    end else begin
      enable_s = '0;
    end
  end

  // Job FSM, fill/drain counters and buffer occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      num_tiles_r     <= TW'(0);
      sel_r           <= '0;
      read_buf_r      <= 1'b0;
      buf_full_r      <= 2'b00;
      row_k_r         <= ROW_W'(0);
      tiles_filled_r  <= TW'(0);
      tiles_drained_r <= TW'(0);
      bit_idx_r       <= BIT_W'(0);
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_start) begin
            num_tiles_r     <= i_num_tiles;
            sel_r           <= i_brick_sel;
            buf_full_r      <= 2'b00;
            row_k_r         <= ROW_W'(0);
            tiles_filled_r  <= TW'(0);
            tiles_drained_r <= TW'(0);
            bit_idx_r       <= BIT_W'(0);
            state_r         <= (i_num_tiles == TW'(0)) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (tiles_drained_r == num_tiles_r) begin
            state_r <= S_DONE;
          end
          if (fill_s) begin
            if (row_k_r == LAST_ROW) begin
              row_k_r                  <= ROW_W'(0);
              buf_full_r[~read_buf_r]  <= 1'b1;
              tiles_filled_r           <= tiles_filled_r + TW'(1);
            end else begin
              row_k_r <= row_k_r + ROW_W'(1);
            end
          end
          // Drain completion clears the other buffer, so it may coincide with a fill completion.
          if (accept_s) begin
            if (bit_idx_r == LAST_BIT) begin
              bit_idx_r               <= BIT_W'(0);
              buf_full_r[read_buf_r]  <= 1'b0;
              tiles_drained_r         <= tiles_drained_r + TW'(1);
            end else begin
              bit_idx_r <= bit_idx_r + BIT_W'(1);
            end
          end
          // Occupancy bits are indexed by physical buffer, so a swap only flips the pointer.
          if (swap_s) begin
            read_buf_r <= ~read_buf_r;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy         = (state_r != S_IDLE);
  assign o_done         = (state_r == S_DONE);
  assign o_mem_req      = mem_req_s;
  assign o_sel          = sel_r;
  assign o_enable       = enable_s;
  assign o_read_buf     = read_buf_r;
  assign o_stream_valid = stream_valid_s;
  assign o_bit_idx      = bit_idx_r;

`ifdef DISPATCH_SEQ_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where a slice is offered but not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == S_IDLE) && i_start) begin
      stall_cnt_r <= 32'd0;
    end else if (stream_valid_s && !i_stream_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_r;
`endif

endmodule
